lc3_latency_memory: RTL and testbench
=====================================

Name: lc3_latency_memory

Overview:
- Parametrised single-port word memory model for the LC3 instruction and data sides; successor to the fixed, zero-wait memories in the LC3 bench.
- Width, depth and independent read/write latencies are configurable.
- `complete` is a real registered handshake pulse rather than a constant, so the LC3 core's `complete_instr` and `complete_data` wait logic is exercised.
- One instance per side (I-mem with `wr` tied low, D-mem with both strobes).

Parameters:
- `DATA_W`, 16, word width in bits.
- `ADDR_W`, 16, address width; depth = 2**`ADDR_W` words.
- `RD_LAT`, 1, cycles from read acceptance to the `complete` pulse, legal 1..16.
- `WR_LAT`, 1, cycles from write acceptance to the `complete` pulse, legal 1..16.

Ports:
- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `addr`  in  `ADDR_W`  word address, sampled on acceptance.
- `din`  in  `DATA_W`  write data, sampled on acceptance.
- `rd`  in  1  read request, level.
- `wr`  in  1  write request, level.
- `dout`  out  `DATA_W`  read data, registered, valid when `complete` is high after a read.
- `complete`  out  1  one-cycle pulse: the accepted access has finished.
- `busy`  out  1  an access is in flight; new requests are ignored.

Behaviour:
- Reset (`reset`=0, asynchronous) clears control state only; the memory array is not cleared:
  - `dout`=0, `complete`=0, `busy`=0.
  - State=IDLE, counter=0.
  - Any pending write is discarded and never committed.
- Acceptance: at a rising edge E0 with `busy`=0 and (`rd`|`wr`)=1, latch `addr`, `din` and op.
  - `rd` has priority: if both are high, the op is a read and the write is dropped.
- Latency rule, with LAT = `RD_LAT` or `WR_LAT` by op:
  - `complete` rises after edge E0+LAT-1 and is high for exactly one cycle.
  - LAT=1: `complete` and `dout` update at E0 itself (same timing as the legacy memory with an always-true handshake).
- States:
  - IDLE: on acceptance with LAT=1, stay in IDLE and pulse `complete`. On acceptance with LAT>1, go to WAIT, set `busy`=1, load counter=LAT-2.
  - WAIT: at each edge, if counter≠0 decrement it. Otherwise perform the access, pulse `complete`, clear `busy` and return to IDLE.
- Access timing:
  - A read samples the array at its completion edge and loads `dout`.
  - A write commits `din` to `ram[addr]` at its completion edge.
  - `dout` holds its last read value through writes and idle cycles.
- `busy` and `complete` are never high in the same cycle. The edge ending the `complete` cycle may accept a new request, so a held `rd` with LAT=1 completes every cycle and with LAT=N completes every N cycles.
- Requests seen while `busy`=1 are ignored (no queue). The requester holds `rd`/`wr` until it sees `complete`.
- A change of `addr`/`din` during WAIT has no effect; the latched values are used.
- Read-after-write to the same address returns the new data, because the write commits before the next access is accepted.
- Addresses wrap modulo 2**`ADDR_W` by construction.
- Initial contents are loaded by `$readmemh` from the bench into the array member `ram`; the array name is fixed so hierarchical loads work.
- Illegal LAT (0 or >16) triggers an elaboration-time `$error`.

Test Plan:
- `RD_LAT`=1: preload `ram[3000]`=1234, hold `rd`=1 with `addr`=3000 from edge 0 -> `dout`=1234 and `complete`=1 after edge 0. Stepping `addr`=3001, 3002 on successive cycles gives one completion per cycle with the preloaded values, and `busy` stays 0.
- `RD_LAT`=3: read `addr`=0x300A (preloaded 0002) accepted at E0 -> `busy`=1 after E0 and E1; `dout`=0002 and `complete`=1 after E2; `busy`=0; no other `complete`.
- `WR_LAT`=2: write 0x00FF to 0x300B at E0 while toggling `addr` during WAIT -> `complete` after E1 only. A following 1-cycle read of 0x300B returns 0x00FF, and `dout` is unchanged until that read.
- `rd`=`wr`=1 with `addr`=5, `din`=AAAA, where `ram[5]`=1111 -> read performed, `dout`=1111, and `ram[5]` is still 1111.
- Second request asserted during `busy` (`RD_LAT`=4) -> ignored until `complete`. It is accepted at the next edge and completes 4 cycles later, for exactly two `complete` pulses in total.
- `reset` driven low mid-WAIT of a write (`WR_LAT`=4, between edges) -> `busy`, `complete` and `dout` go to 0 immediately without waiting for a clock edge, and the target word keeps its old value. After release, a fresh read works with the normal latency.

Source files
------------

// File: rtl/lc3_latency_memory.sv
// Single-port LC3 word memory with independent, configurable read and write latency.
// `complete` is a registered one-cycle pulse that marks the end of each accepted access.
module lc3_latency_memory #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] dout,
    output logic              complete,
    output logic              busy
);
    if (RD_LAT < 1 || RD_LAT > 16 || WR_LAT < 1 || WR_LAT > 16) begin : g_bad_latency
        $error("lc3_latency_memory: RD_LAT and WR_LAT must be in 1..16");
    end

    localparam logic [3:0] RD_LOAD = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
    localparam logic [3:0] WR_LOAD = (WR_LAT > 1) ? 4'(WR_LAT - 2) : 4'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [3:0]        count;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;

    logic [DATA_W-1:0] ram [0:(2**ADDR_W)-1];

    logic              accept;
    logic              finish;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_din;

    // In IDLE the live request is the access; in WAIT the latched one is.
    always_comb begin
        accept    = 1'b0;
        finish    = 1'b0;
        acc_write = op_write;
        acc_addr  = addr_q;
        acc_din   = din_q;
        if (state == IDLE) begin
            accept    = rd | wr;
            acc_write = ~rd;
            acc_addr  = addr;
            acc_din   = din;
            finish    = accept & (acc_write ? (WR_LAT == 1) : (RD_LAT == 1));
        end else begin
            finish = (count == 4'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && finish && acc_write) begin
            ram[acc_addr] <= acc_din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            dout     <= '0;
            complete <= 1'b0;
            busy     <= 1'b0;
        end else begin
            complete <= finish;
            if (finish) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (!acc_write) begin
                    dout <= ram[acc_addr];
                end
            end else if (state == IDLE) begin
                if (accept) begin
                    state    <= WAIT;
                    busy     <= 1'b1;
                    count    <= acc_write ? WR_LOAD : RD_LOAD;
                    op_write <= acc_write;
                    addr_q   <= addr;
                    din_q    <= din;
                end
            end else begin
                count <= count - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_lc3_latency_memory.sv
// Directed bench for lc3_latency_memory: a cycle table for RD_LAT=1/WR_LAT=2 plus
// hand sequences for the multi-cycle, busy-overlap and mid-access reset cases.
module tb_lc3_latency_memory;
    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a, rd_a, wr_a, complete_a, busy_a;
    logic [15:0] addr_a, din_a, dout_a;
    logic        rst_b, rd_b, wr_b, complete_b, busy_b;
    logic [15:0] addr_b, din_b, dout_b;
    logic        rst_c, rd_c, wr_c, complete_c, busy_c;
    logic [15:0] addr_c, din_c, dout_c;

    lc3_latency_memory #(.DATA_W(16), .ADDR_W(16), .RD_LAT(1), .WR_LAT(2)) u_a (
        .clock(clock), .reset(rst_a), .addr(addr_a), .din(din_a), .rd(rd_a), .wr(wr_a),
        .dout(dout_a), .complete(complete_a), .busy(busy_a));
    lc3_latency_memory #(.DATA_W(16), .ADDR_W(16), .RD_LAT(3), .WR_LAT(4)) u_b (
        .clock(clock), .reset(rst_b), .addr(addr_b), .din(din_b), .rd(rd_b), .wr(wr_b),
        .dout(dout_b), .complete(complete_b), .busy(busy_b));
    lc3_latency_memory #(.DATA_W(16), .ADDR_W(16), .RD_LAT(4), .WR_LAT(1)) u_c (
        .clock(clock), .reset(rst_c), .addr(addr_c), .din(din_c), .rd(rd_c), .wr(wr_c),
        .dout(dout_c), .complete(complete_c), .busy(busy_c));

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_c;
        logic        exp_b;
        logic [15:0] exp_d;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;
    int pulses_c = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_b(input string tag, input logic exp_c, input logic exp_b,
                          input logic [15:0] exp_d);
        @(negedge clock);
        check({tag, " complete"}, {15'd0, complete_b}, {15'd0, exp_c});
        check({tag, " busy"}, {15'd0, busy_b}, {15'd0, exp_b});
        check({tag, " dout"}, dout_b, exp_d);
    endtask

    task automatic step_c(input string tag, input logic exp_c, input logic exp_b,
                          input logic [15:0] exp_d);
        @(negedge clock);
        if (complete_c === 1'b1) pulses_c++;
        check({tag, " complete"}, {15'd0, complete_c}, {15'd0, exp_c});
        check({tag, " busy"}, {15'd0, busy_c}, {15'd0, exp_b});
        check({tag, " dout"}, dout_c, exp_d);
    endtask

    initial begin
        // Each row: inputs for one cycle, outputs expected after that cycle's rising edge.
        vecs[0]  = '{1'b0, 1'b1, 16'h3000, 16'h1234, 1'b0, 1'b1, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 16'h3000, 16'h1234, 1'b1, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'h3001, 16'h5678, 1'b0, 1'b1, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 16'h3001, 16'h5678, 1'b1, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 16'h3002, 16'h9abc, 1'b0, 1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 16'h3002, 16'h9abc, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 16'h0005, 16'h1111, 1'b0, 1'b1, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 16'h0005, 16'h1111, 1'b1, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b1, 1'b0, 16'h1234};
        vecs[10] = '{1'b1, 1'b0, 16'h3001, 16'h0000, 1'b1, 1'b0, 16'h5678};
        vecs[11] = '{1'b1, 1'b0, 16'h3002, 16'h0000, 1'b1, 1'b0, 16'h9abc};
        vecs[12] = '{1'b0, 1'b1, 16'h300b, 16'h00ff, 1'b0, 1'b1, 16'h9abc};
        vecs[13] = '{1'b0, 1'b1, 16'h3000, 16'hffff, 1'b1, 1'b0, 16'h9abc};
        vecs[14] = '{1'b1, 1'b0, 16'h300b, 16'h0000, 1'b1, 1'b0, 16'h00ff};
        vecs[15] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b1, 1'b0, 16'h1234};
        vecs[16] = '{1'b1, 1'b1, 16'h0005, 16'haaaa, 1'b1, 1'b0, 16'h1111};
        vecs[17] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h1111};
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1111};
        vecs[19] = '{1'b0, 1'b1, 16'hffff, 16'hbeef, 1'b0, 1'b1, 16'h1111};
        vecs[20] = '{1'b0, 1'b1, 16'hffff, 16'hbeef, 1'b1, 1'b0, 16'h1111};
        vecs[21] = '{1'b1, 1'b0, 16'hffff, 16'h0000, 1'b1, 1'b0, 16'hbeef};
        vecs[22] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hbeef};

        rst_a = 1'b0; rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
        rst_b = 1'b0; rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
        rst_c = 1'b0; rd_c = 1'b0; wr_c = 1'b0; addr_c = '0; din_c = '0;

        @(negedge clock);
        check("reset a dout", dout_a, 16'h0000);
        check("reset a complete", {15'd0, complete_a}, 16'h0000);
        check("reset a busy", {15'd0, busy_a}, 16'h0000);
        check("reset b busy", {15'd0, busy_b}, 16'h0000);
        check("reset c complete", {15'd0, complete_c}, 16'h0000);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        for (int i = 0; i < NV; i++) begin
            rd_a = vecs[i].rd; wr_a = vecs[i].wr; addr_a = vecs[i].addr; din_a = vecs[i].din;
            @(negedge clock);
            check($sformatf("a%0d complete", i), {15'd0, complete_a}, {15'd0, vecs[i].exp_c});
            check($sformatf("a%0d busy", i), {15'd0, busy_a}, {15'd0, vecs[i].exp_b});
            check($sformatf("a%0d dout", i), dout_a, vecs[i].exp_d);
        end
        rd_a = 1'b0; wr_a = 1'b0;

        // WR_LAT=4 write of 0002 to 300A, then RD_LAT=3 read back.
        wr_b = 1'b1; addr_b = 16'h300a; din_b = 16'h0002;
        step_b("bw e0", 1'b0, 1'b1, 16'h0000);
        step_b("bw e1", 1'b0, 1'b1, 16'h0000);
        step_b("bw e2", 1'b0, 1'b1, 16'h0000);
        step_b("bw e3", 1'b1, 1'b0, 16'h0000);
        wr_b = 1'b0;
        step_b("bw idle", 1'b0, 1'b0, 16'h0000);
        rd_b = 1'b1;
        step_b("br e0", 1'b0, 1'b1, 16'h0000);
        step_b("br e1", 1'b0, 1'b1, 16'h0000);
        step_b("br e2", 1'b1, 1'b0, 16'h0002);
        rd_b = 1'b0;
        step_b("br e3", 1'b0, 1'b0, 16'h0002);
        step_b("br e4", 1'b0, 1'b0, 16'h0002);

        // Asynchronous reset in the middle of a pending write.
        wr_b = 1'b1; din_b = 16'h7777;
        step_b("bx e0", 1'b0, 1'b1, 16'h0002);
        step_b("bx e1", 1'b0, 1'b1, 16'h0002);
        rst_b = 1'b0; wr_b = 1'b0;
        #1;
        check("bx async busy", {15'd0, busy_b}, 16'h0000);
        check("bx async complete", {15'd0, complete_b}, 16'h0000);
        check("bx async dout", dout_b, 16'h0000);
        @(negedge clock);
        rst_b = 1'b1;
        rd_b = 1'b1;
        step_b("by e0", 1'b0, 1'b1, 16'h0000);
        step_b("by e1", 1'b0, 1'b1, 16'h0000);
        step_b("by e2", 1'b1, 1'b0, 16'h0002);
        rd_b = 1'b0;
        step_b("by e3", 1'b0, 1'b0, 16'h0002);

        // RD_LAT=4 with a second request held across busy.
        wr_c = 1'b1; addr_c = 16'h300c; din_c = 16'h4444;
        step_c("cw0", 1'b1, 1'b0, 16'h0000);
        addr_c = 16'h300d; din_c = 16'h5555;
        step_c("cw1", 1'b1, 1'b0, 16'h0000);
        wr_c = 1'b0;
        step_c("cw idle", 1'b0, 1'b0, 16'h0000);
        pulses_c = 0;
        rd_c = 1'b1; addr_c = 16'h300c;
        step_c("cr e0", 1'b0, 1'b1, 16'h0000);
        addr_c = 16'h300d;
        step_c("cr e1", 1'b0, 1'b1, 16'h0000);
        step_c("cr e2", 1'b0, 1'b1, 16'h0000);
        step_c("cr e3", 1'b1, 1'b0, 16'h4444);
        step_c("cr e4", 1'b0, 1'b1, 16'h4444);
        step_c("cr e5", 1'b0, 1'b1, 16'h4444);
        step_c("cr e6", 1'b0, 1'b1, 16'h4444);
        step_c("cr e7", 1'b1, 1'b0, 16'h5555);
        rd_c = 1'b0;
        step_c("cr e8", 1'b0, 1'b0, 16'h5555);
        step_c("cr e9", 1'b0, 1'b0, 16'h5555);
        check("c pulse count", 16'(pulses_c), 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
